// File: rtl/systola_pkg.sv
// Shared types for the systolic result path: drain FSM states,
// result word type and the row-index width helper.
package systola_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } drain_state_e;

   localparam int OUTWIDTH = 32;
   localparam int RESW     = OUTWIDTH + 1;

   typedef logic [RESW-1:0] result_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/result_slot.sv
// One PE row holding slot: result register, full flag, overrun pulse.
// Ports: clk, rst, cap/din (capture), clr (drain load), dout, full, ovr.
module result_slot
   import systola_pkg::*;
#(
   parameter int W = RESW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cap,
   input  logic [W-1:0] din,
   input  logic         clr,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         ovr
);

   // A drain load frees the slot in the same cycle, so a
   // coincident capture belongs to the next tile.
   logic full_eff;

   assign full_eff = full && !clr;
   assign ovr      = cap && full_eff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
         full <= 1'b0;
      end else if (cap && !full_eff) begin
         dout <= din;
         full <= 1'b1;
      end else if (clr) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/pe_result_drain.sv
// Collects one result per PE row, then drains the tile in row order
// on a valid/ready stream. Ports: pe_r/pe_valid in, out_* stream, overrun, tile_cnt.
module pe_result_drain
   import systola_pkg::*;
#(
   parameter int OUTWIDTH = 32,
   parameter int NPE      = 4,
   parameter int CNTW     = 16,
   localparam int IDXW    = idx_w(NPE),
   localparam int RW      = OUTWIDTH + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NPE*RW-1:0] pe_r,
   input  logic [NPE-1:0]    pe_valid,
   output logic [RW-1:0]     out_data,
   output logic [IDXW-1:0]   out_idx,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic [CNTW-1:0]   tile_cnt
);

   localparam logic [IDXW-1:0] LAST = IDXW'(NPE - 1);

   drain_state_e    state;
   logic [IDXW-1:0] ptr;
   logic [NPE-1:0]  hold_full;
   logic [NPE-1:0]  clr;
   logic [NPE-1:0]  ovr;
   logic [RW-1:0]   hold [NPE];
   logic            fire;
   logic            load;

   assign fire = out_valid && out_ready;

   // Once the last beat is in the output register, the pointer has
   // wrapped; hold off until it leaves so the next tile is not
   // started before it is complete.
   assign load = (state == DRAIN) && hold_full[ptr] &&
                 (!out_valid || (out_ready && !out_last));

   always_comb begin
      clr = '0;
      if (load) clr[ptr] = 1'b1;
   end

   for (genvar i = 0; i < NPE; i++) begin : g_slot
      result_slot #(.W(RW)) u_slot (
         .clk  (clk),
         .rst  (rst),
         .cap  (pe_valid[i]),
         .din  (pe_r[i*RW +: RW]),
         .clr  (clr[i]),
         .dout (hold[i]),
         .full (hold_full[i]),
         .ovr  (ovr[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         ptr       <= '0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         tile_cnt  <= '0;
      end else begin
         if (|ovr) overrun <= 1'b1;

         unique case (state)
            COLLECT: if (&hold_full) state <= DRAIN;
            DRAIN:   if (fire && out_last) state <= COLLECT;
         endcase

         if (fire && out_last) tile_cnt <= tile_cnt + CNTW'(1);

         if (load) begin
            out_data  <= hold[ptr];
            out_idx   <= ptr;
            out_last  <= (ptr == LAST);
            out_valid <= 1'b1;
            ptr       <= (ptr == LAST) ? '0 : ptr + IDXW'(1);
         end else if (fire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: directed corner cases,
// a vector table of permuted tiles, random traffic and counter wrap.
module tb_pe_result_drain;

   localparam int RW = 33;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*RW-1:0] pe_r = '0;
   logic [N-1:0]    pe_valid = '0;
   logic [RW-1:0]   out_data;
   logic [1:0]      out_idx;
   logic            out_last;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            overrun;
   logic [15:0]     tile_cnt;

   logic [N*RW-1:0] pe_r2 = '0;
   logic [N-1:0]    pe_valid2 = '0;
   logic [RW-1:0]   out_data2;
   logic [1:0]      out_idx2;
   logic            out_last2;
   logic            out_valid2;
   logic            out_ready2 = 1'b1;
   logic            overrun2;
   logic [1:0]      tile_cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pe_result_drain #(.OUTWIDTH(32), .NPE(4), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .pe_r(pe_r), .pe_valid(pe_valid),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun), .tile_cnt(tile_cnt)
   );

   pe_result_drain #(.OUTWIDTH(32), .NPE(4), .CNTW(2)) dut2 (
      .clk(clk), .rst(rst), .pe_r(pe_r2), .pe_valid(pe_valid2),
      .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .overrun(overrun2), .tile_cnt(tile_cnt2)
   );

   typedef struct {
      int            order [4];
      logic [RW-1:0] vals [4];
      logic [RW-1:0] exp [4];
      int            exp_cnt;
   } vec_t;

   vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic set_row(input int r, input logic [RW-1:0] v);
      pe_r[r*RW +: RW] = v;
      pe_valid[r] = 1'b1;
   endtask

   task automatic fill(input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic [RW-1:0] c, input logic [RW-1:0] d);
      set_row(0, a);
      set_row(1, b);
      set_row(2, c);
      set_row(3, d);
      tick();
      pe_valid = '0;
   endtask

   task automatic drain_check(input logic [RW-1:0] e [4], input string tag);
      int k;
      k = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         if (out_valid) begin
            chk({tag, "_idx"}, 64'(out_idx), 64'(k));
            chk({tag, "_data"}, 64'(out_data), 64'(e[k]));
            chk({tag, "_last"}, 64'(out_last), 64'(k == 3));
            k++;
         end
         tick();
      end
      chk({tag, "_beats"}, 64'(k), 64'd4);
   endtask

   initial begin
      logic [RW-1:0] e [4];
      logic [RW-1:0] q [4][$];
      logic [RW-1:0] v;
      int sent [4];
      int drained [4];
      int nxt;
      int done;
      int wrap_exp [5];
      bit seen;

      tbl[0].order = '{3, 2, 1, 0};
      tbl[0].vals  = '{33'h0_0000_0001, 33'h0_0000_0002,
                       33'h0_0000_0003, 33'h0_0000_0004};
      tbl[0].exp   = '{33'h0_0000_0001, 33'h0_0000_0002,
                       33'h0_0000_0003, 33'h0_0000_0004};
      tbl[0].exp_cnt = 2;
      tbl[1].order = '{2, 0, 3, 1};
      tbl[1].vals  = '{33'h1_0000_0000, 33'h0_0000_0000,
                       33'h1_FFFF_FFFF, 33'h0_DEAD_BEEF};
      tbl[1].exp   = '{33'h1_0000_0000, 33'h0_0000_0000,
                       33'h1_FFFF_FFFF, 33'h0_DEAD_BEEF};
      tbl[1].exp_cnt = 3;
      tbl[2].order = '{1, 3, 0, 2};
      tbl[2].vals  = '{33'h0_AAAA_AAAA, 33'h1_5555_5555,
                       33'h0_8000_0000, 33'h1_7FFF_FFFF};
      tbl[2].exp   = '{33'h0_AAAA_AAAA, 33'h1_5555_5555,
                       33'h0_8000_0000, 33'h1_7FFF_FFFF};
      tbl[2].exp_cnt = 4;
      tbl[3].order = '{0, 1, 2, 3};
      tbl[3].vals  = '{33'h0_1234_5678, 33'h0_1234_5678,
                       33'h1_0000_0001, 33'h0_0000_00FF};
      tbl[3].exp   = '{33'h0_1234_5678, 33'h0_1234_5678,
                       33'h1_0000_0001, 33'h0_0000_00FF};
      tbl[3].exp_cnt = 5;

      // reset state
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_tile_cnt", 64'(tile_cnt), 64'd0);
      rst = 1'b0;
      tick();

      // staggered tile and latency
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         pe_valid = '0;
         set_row(r, RW'((r + 1) * 10));
         tick();
      end
      pe_valid = '0;
      chk("t2_lat0", 64'(out_valid), 64'd0);
      tick();
      chk("t2_lat1", 64'(out_valid), 64'd0);
      tick();
      for (int r = 0; r < 4; r++) begin
         chk("t2_valid", 64'(out_valid), 64'd1);
         chk("t2_data", 64'(out_data), 64'((r + 1) * 10));
         chk("t2_idx", 64'(out_idx), 64'(r));
         chk("t2_last", 64'(out_last), 64'(r == 3));
         tick();
      end
      chk("t2_idle", 64'(out_valid), 64'd0);
      chk("t2_tile_cnt", 64'(tile_cnt), 64'd1);

      // backpressure at beat 1
      fill(10, 20, 30, 40);
      tick();
      tick();
      chk("t3_b0", 64'(out_data), 64'd10);
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t3_hold_valid", 64'(out_valid), 64'd1);
         chk("t3_hold_data", 64'(out_data), 64'd20);
         chk("t3_hold_idx", 64'(out_idx), 64'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("t3_b2", 64'(out_data), 64'd30);
      chk("t3_b2_idx", 64'(out_idx), 64'd2);
      tick();
      chk("t3_b3", 64'(out_data), 64'd40);
      chk("t3_b3_last", 64'(out_last), 64'd1);
      tick();
      chk("t3_idle", 64'(out_valid), 64'd0);
      chk("t3_tile_cnt", 64'(tile_cnt), 64'd2);

      // next-tile capture on the row-0 load cycle
      fill(1, 2, 3, 4);
      tick();
      set_row(0, 33'h1_FFFF_FFFF);
      tick();
      pe_valid = '0;
      chk("t4_b0", 64'(out_data), 64'd1);
      chk("t4_no_ovr", 64'(overrun), 64'd0);
      tick();
      tick();
      tick();
      chk("t4_b3_last", 64'(out_last), 64'd1);
      tick();
      chk("t4_tile_cnt", 64'(tile_cnt), 64'd3);
      set_row(1, 5);
      set_row(2, 6);
      set_row(3, 7);
      tick();
      pe_valid = '0;
      e = '{33'h1_FFFF_FFFF, 33'd5, 33'd6, 33'd7};
      drain_check(e, "t4_tileb");
      chk("t4_tile_cnt2", 64'(tile_cnt), 64'd4);
      chk("t4_no_ovr2", 64'(overrun), 64'd0);

      // overrun on a held row
      out_ready = 1'b0;
      fill(100, 101, 102, 103);
      tick();
      tick();
      chk("t5_b0", 64'(out_data), 64'd100);
      set_row(2, 999);
      tick();
      pe_valid = '0;
      chk("t5_overrun", 64'(overrun), 64'd1);
      e = '{33'd100, 33'd101, 33'd102, 33'd103};
      drain_check(e, "t5_drain");
      chk("t5_tile_cnt", 64'(tile_cnt), 64'd5);
      chk("t5_sticky", 64'(overrun), 64'd1);

      // reset mid-drain
      out_ready = 1'b1;
      fill(200, 201, 202, 203);
      tick();
      tick();
      tick();
      tick();
      chk("t1_mid_idx", 64'(out_idx), 64'd2);
      rst = 1'b1;
      #1;
      chk("t1_valid", 64'(out_valid), 64'd0);
      chk("t1_tile_cnt", 64'(tile_cnt), 64'd0);
      chk("t1_overrun", 64'(overrun), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t1_quiet", 64'(out_valid), 64'd0);
      fill(300, 301, 302, 303);
      e = '{33'd300, 33'd301, 33'd302, 33'd303};
      drain_check(e, "t1_next");
      chk("t1_tile_cnt2", 64'(tile_cnt), 64'd1);

      // vector table: rows arrive in permuted order
      for (int t = 0; t < 4; t++) begin
         for (int j = 0; j < 4; j++) begin
            pe_valid = '0;
            set_row(tbl[t].order[j], tbl[t].vals[tbl[t].order[j]]);
            tick();
         end
         pe_valid = '0;
         drain_check(tbl[t].exp, "tbl");
         chk("tbl_cnt", 64'(tile_cnt), 64'(tbl[t].exp_cnt));
      end

      // random traffic against a per-row queue model
      for (int r = 0; r < 4; r++) begin
         sent[r] = 0;
         drained[r] = 0;
      end
      nxt = 0;
      done = 0;
      for (int cyc = 0; cyc < 5000 && done < 25; cyc++) begin
         chk("rnd_tile_cnt", 64'(tile_cnt), 64'(5 + done));
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) begin
            chk("rnd_idx", 64'(out_idx), 64'(nxt));
            chk("rnd_last", 64'(out_last), 64'(nxt == 3));
            if (q[nxt].size() > 0) begin
               v = q[nxt].pop_front();
               chk("rnd_data", 64'(out_data), 64'(v));
            end else begin
               chk("rnd_unexpected", 64'(out_data), 64'h1_0000_0000_0);
            end
            drained[nxt]++;
            if (nxt == 3) done++;
            nxt = (nxt + 1) % 4;
         end
         pe_valid = '0;
         for (int r = 0; r < 4; r++) begin
            if (sent[r] == drained[r] && sent[r] < 25 &&
                $urandom_range(0, 1) == 1) begin
               v = {1'($urandom_range(0, 1)), 32'($urandom)};
               set_row(r, v);
               q[r].push_back(v);
               sent[r]++;
            end
         end
         tick();
      end
      pe_valid = '0;
      chk("rnd_done", 64'(done), 64'd25);
      chk("rnd_final_cnt", 64'(tile_cnt), 64'd30);
      chk("rnd_no_ovr", 64'(overrun), 64'd0);

      // tile counter wrap on the CNTW=2 instance
      wrap_exp = '{1, 2, 3, 0, 1};
      for (int t = 0; t < 5; t++) begin
         for (int r = 0; r < 4; r++) pe_r2[r*RW +: RW] = RW'(t * 4 + r);
         pe_valid2 = '1;
         tick();
         pe_valid2 = '0;
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            if (out_valid2 && out_last2) seen = 1'b1;
            tick();
         end
         chk("wrap_seen", 64'(seen), 64'd1);
         chk("wrap_cnt", 64'(tile_cnt2), 64'(wrap_exp[t]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
